// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM peripheral on an Avalon slave bus. Channels share one period counter
// that advances on a prescaler tick. Period, prescaler and duty writes are double-buffered
// and reach the active copies only at the period boundary (or continuously while stopped).
// Optional feature macro: PWM_POLARITY_EN adds the per-channel POL register at address 6.
module avalon_pwm_multi #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                cs,
  input  logic                wr_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [31:0]         wr_data,
  output logic [31:0]         rd_data,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                irq
);

  localparam logic [ADDR_W-1:0] AddrPeriod = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] AddrPresc  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] AddrChEn   = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] AddrCount  = ADDR_W'(5);
`ifdef PWM_POLARITY_EN
  localparam logic [ADDR_W-1:0] AddrPol    = ADDR_W'(6);
`endif

  function automatic logic [31:0] zext(input logic [CNT_W-1:0] v);
    logic [31:0] r;
    r = '0;
    r[CNT_W-1:0] = v;
    return r;
  endfunction

  logic                we;
  logic                run, tick, wrap_cyc, load_a;
  logic [CNT_W-1:0]    period_q, period_d, presc_q, presc_d;
  logic [CNT_W-1:0]    period_a_q, period_a_d, presc_a_q, presc_a_d;
  logic [CNT_W-1:0]    pcnt_q, pcnt_d, cnt_q, cnt_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [CHANNELS-1:0] ch_en_q, ch_en_d, pwm_q, pwm_d, pol;
  logic                wrap_q, wrap_d;
  logic [CNT_W-1:0]    duty_q [CHANNELS];
  logic [CNT_W-1:0]    duty_d [CHANNELS];
  logic [CNT_W-1:0]    duty_a_q [CHANNELS];
  logic [CNT_W-1:0]    duty_a_d [CHANNELS];

  assign we = cs & ~wr_n;

`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0] pol_q, pol_d;
  assign pol = pol_q;
`else
  assign pol = '0;
`endif

  // Shadow register writes from the bus.
  always_comb begin
    period_d = period_q;
    presc_d  = presc_q;
    ctrl_d   = ctrl_q;
    ch_en_d  = ch_en_q;
`ifdef PWM_POLARITY_EN
    pol_d    = pol_q;
`endif
    for (int n = 0; n < CHANNELS; n++) duty_d[n] = duty_q[n];
    if (we) begin
      case (addr)
        AddrPeriod: period_d = wr_data[CNT_W-1:0];
        AddrPresc:  presc_d  = wr_data[CNT_W-1:0];
        AddrCtrl:   ctrl_d   = wr_data[1:0];
        AddrChEn:   ch_en_d  = wr_data[CHANNELS-1:0];
`ifdef PWM_POLARITY_EN
        AddrPol:    pol_d    = wr_data[CHANNELS-1:0];
`endif
        default: ;
      endcase
      for (int n = 0; n < CHANNELS; n++) begin
        if (addr == ADDR_W'(8 + n)) duty_d[n] = wr_data[CNT_W-1:0];
      end
    end
  end

  // Prescaler, period counter, active-copy reload, wrap flag and channel comparators.
  always_comb begin
    run      = ctrl_q[0];
    tick     = run && (pcnt_q == presc_a_q);
    // >= so a shrunk period can never leave the counter stranded above it.
    wrap_cyc = tick && (cnt_q >= period_a_q);
    load_a   = !run || wrap_cyc;

    pcnt_d = (!run || tick) ? '0 : pcnt_q + CNT_W'(1);
    if (!run || wrap_cyc) cnt_d = '0;
    else if (tick)        cnt_d = cnt_q + CNT_W'(1);
    else                  cnt_d = cnt_q;

    // Active copies take the pre-write shadow value on a wrap cycle.
    period_a_d = load_a ? period_q : period_a_q;
    presc_a_d  = load_a ? presc_q  : presc_a_q;
    for (int n = 0; n < CHANNELS; n++) begin
      duty_a_d[n] = load_a ? duty_q[n] : duty_a_q[n];
      pwm_d[n]    = (run & ch_en_q[n] & (cnt_q < duty_a_q[n])) ^ pol[n];
    end

    // Set has priority over a same-cycle clearing write.
    wrap_d = wrap_cyc | (wrap_q & ~(we && (addr == AddrStatus) && wr_data[0]));
  end

  // Register state with synchronous clear.
  always_ff @(posedge clk) begin
    if (clr) begin
      period_q   <= '0;
      presc_q    <= '0;
      period_a_q <= '0;
      presc_a_q  <= '0;
      pcnt_q     <= '0;
      cnt_q      <= '0;
      ctrl_q     <= '0;
      ch_en_q    <= '0;
      pwm_q      <= '0;
      wrap_q     <= 1'b0;
`ifdef PWM_POLARITY_EN
      pol_q      <= '0;
`endif
      for (int n = 0; n < CHANNELS; n++) begin
        duty_q[n]   <= '0;
        duty_a_q[n] <= '0;
      end
    end else begin
      period_q   <= period_d;
      presc_q    <= presc_d;
      period_a_q <= period_a_d;
      presc_a_q  <= presc_a_d;
      pcnt_q     <= pcnt_d;
      cnt_q      <= cnt_d;
      ctrl_q     <= ctrl_d;
      ch_en_q    <= ch_en_d;
      pwm_q      <= pwm_d;
      wrap_q     <= wrap_d;
`ifdef PWM_POLARITY_EN
      pol_q      <= pol_d;
`endif
      for (int n = 0; n < CHANNELS; n++) begin
        duty_q[n]   <= duty_d[n];
        duty_a_q[n] <= duty_a_d[n];
      end
    end
  end

  // Zero-wait-state read mux; shadows are returned, unmapped addresses read 0.
  always_comb begin
    rd_data = '0;
    case (addr)
      AddrPeriod: rd_data = zext(period_q);
      AddrPresc:  rd_data = zext(presc_q);
      AddrCtrl:   rd_data[1:0] = ctrl_q;
      AddrChEn:   rd_data[CHANNELS-1:0] = ch_en_q;
      AddrStatus: rd_data[0] = wrap_q;
      AddrCount:  rd_data = zext(cnt_q);
`ifdef PWM_POLARITY_EN
      AddrPol:    rd_data[CHANNELS-1:0] = pol_q;
`endif
      default: ;
    endcase
    for (int n = 0; n < CHANNELS; n++) begin
      if (addr == ADDR_W'(8 + n)) rd_data = zext(duty_q[n]);
    end
  end

  assign pwm_out = pwm_q;
  assign irq     = wrap_q & ctrl_q[1];

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Directed self-checking bench for avalon_pwm_multi (default parameters).
module tb_avalon_pwm_multi;

  logic        clk = 1'b0;
  logic        clr, cs, wr_n;
  logic [3:0]  addr;
  logic [31:0] wr_data, rd_data;
  logic [7:0]  pwm_out;
  logic        irq;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  avalon_pwm_multi dut (
    .clk    (clk),
    .clr    (clr),
    .cs     (cs),
    .wr_n   (wr_n),
    .addr   (addr),
    .wr_data(wr_data),
    .rd_data(rd_data),
    .pwm_out(pwm_out),
    .irq    (irq)
  );

  // Bus write: executes on the posedge between the two negedges.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_n = 1'b0; addr = a; wr_data = d;
    @(negedge clk);
    cs = 1'b0; wr_n = 1'b1;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a; cs = 1'b1; wr_n = 1'b1;
    #1 d = rd_data;
    cs = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    clr = 1'b1; cs = 1'b0; wr_n = 1'b1; addr = '0; wr_data = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    checks++;
    if (pwm_out !== 8'h00) begin
      errors++; $display("FAIL reset_pwm got=%h exp=00", pwm_out);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL reset_irq got=%b exp=0", irq);
    end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL reset_read addr=%0d got=%h exp=0", a, d);
      end
    end
    wr(4'd0, 32'd9);
    rd(4'd0, d);
    checks++;
    if (d !== 32'd9) begin
      errors++; $display("FAIL period_readback got=%0d exp=9", d);
    end
    rd(4'd5, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL count_stopped got=%0d exp=0", d);
    end
    wr(4'd7, 32'h5);
    rd(4'd7, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL reserved_addr7 got=%h exp=0", d);
    end
    wr(4'd5, 32'h3);
    rd(4'd5, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL count_write_ignored got=%h exp=0", d);
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    logic [7:0]  exp_pwm;
    wr(4'd2, 32'd0); wr(4'd4, 32'd1);
    wr(4'd0, 32'd9); wr(4'd1, 32'd0); wr(4'd8, 32'd3); wr(4'd3, 32'd1);
    wr(4'd2, 32'd1);
    addr = 4'd5;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      exp_pwm = (((k - 1) % 10) < 3) ? 8'h01 : 8'h00;
      checks++;
      if (rd_data !== 32'(k % 10)) begin
        errors++; $display("FAIL basic_count k=%0d got=%0d exp=%0d", k, rd_data, k % 10);
      end
      checks++;
      if (pwm_out !== exp_pwm) begin
        errors++; $display("FAIL basic_pwm k=%0d got=%h exp=%h", k, pwm_out, exp_pwm);
      end
    end
    rd(4'd4, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL basic_wrap got=%h exp=1", d);
    end
  endtask

  task automatic test_presc;
    logic [31:0] d;
    wr(4'd2, 32'd0); wr(4'd4, 32'd1);
    wr(4'd1, 32'd2); wr(4'd0, 32'd4);
    wr(4'd9, 32'd0); wr(4'd10, 32'd5); wr(4'd3, 32'd6);
    wr(4'd2, 32'd1);
    addr = 4'd5;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      checks++;
      if (rd_data !== 32'((k / 3) % 5)) begin
        errors++; $display("FAIL presc_count k=%0d got=%0d exp=%0d", k, rd_data, (k / 3) % 5);
      end
      checks++;
      if (pwm_out !== 8'h04) begin
        errors++; $display("FAIL presc_pwm k=%0d got=%h exp=04", k, pwm_out);
      end
    end
    rd(4'd4, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL presc_wrap got=%h exp=1", d);
    end
  endtask

  task automatic test_glitch_free;
    logic [7:0] exp_pwm;
    int         exp_cnt;
    wr(4'd2, 32'd0);
    wr(4'd0, 32'd9); wr(4'd1, 32'd0); wr(4'd8, 32'd3); wr(4'd3, 32'd1);
    wr(4'd2, 32'd1);
    cs = 1'b0; wr_n = 1'b1; addr = 4'd5;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      exp_cnt = (k < 30) ? (k % 10) : ((k - 30) % 5);
      if (k <= 10)      exp_pwm = (((k - 1) % 10) < 3) ? 8'h01 : 8'h00;
      else if (k <= 30) exp_pwm = (((k - 1) % 10) < 7) ? 8'h01 : 8'h00;
      else              exp_pwm = 8'h01;
      checks++;
      if (k == 5) begin
        if (rd_data !== 32'd7) begin
          errors++; $display("FAIL glitch_duty_shadow got=%0d exp=7", rd_data);
        end
      end else if (k == 29) begin
        if (rd_data !== 32'd4) begin
          errors++; $display("FAIL glitch_period_shadow got=%0d exp=4", rd_data);
        end
      end else if (rd_data !== 32'(exp_cnt)) begin
        errors++; $display("FAIL glitch_count k=%0d got=%0d exp=%0d", k, rd_data, exp_cnt);
      end
      checks++;
      if (pwm_out !== exp_pwm) begin
        errors++; $display("FAIL glitch_pwm k=%0d got=%h exp=%h", k, pwm_out, exp_pwm);
      end
      if (k == 4) begin
        cs = 1'b1; wr_n = 1'b0; addr = 4'd8; wr_data = 32'd7;
      end else if (k == 28) begin
        cs = 1'b1; wr_n = 1'b0; addr = 4'd0; wr_data = 32'd4;
      end else begin
        cs = 1'b0; wr_n = 1'b1; addr = 4'd5;
      end
    end
  endtask

  task automatic test_irq;
    wr(4'd2, 32'd0); wr(4'd0, 32'd9); wr(4'd4, 32'd1);
    wr(4'd2, 32'd3);
    cs = 1'b0; wr_n = 1'b1; addr = 4'd4;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      cs = 1'b0; wr_n = 1'b1;
      if (k <= 11 || k == 20) begin
        checks++;
        if (rd_data !== 32'(k == 10 || k == 20)) begin
          errors++; $display("FAIL irq_status k=%0d got=%h exp=%0d", k, rd_data,
                             (k == 10 || k == 20));
        end
        checks++;
        if (irq !== (k == 10 || k == 20)) begin
          errors++; $display("FAIL irq_out k=%0d got=%b exp=%0d", k, irq, (k == 10 || k == 20));
        end
      end
      // Clear once after the first wrap, then again on the exact wrap edge.
      if (k == 10 || k == 19) begin
        cs = 1'b1; wr_n = 1'b0; wr_data = 32'd1;
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] d;
    int          n;
    wr(4'd3, 32'd1);
    n = 0;
    while (pwm_out[0] !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++; $display("FAIL midreset_prep got=%b exp=1 (timeout)", pwm_out[0]);
    end
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 8'h00) begin
      errors++; $display("FAIL midreset_pwm got=%h exp=00", pwm_out);
    end
    checks++;
    if (irq !== 1'b0) begin
      errors++; $display("FAIL midreset_irq got=%b exp=0", irq);
    end
    clr = 1'b0;
    for (int a = 0; a < 16; a++) begin
      rd(4'(a), d);
      checks++;
      if (d !== 32'h0) begin
        errors++; $display("FAIL midreset_read addr=%0d got=%h exp=0", a, d);
      end
    end
  endtask

  task automatic test_polarity;
    logic [31:0] d;
    wr(4'd3, 32'd0);
    wr(4'd6, 32'd1);
    @(negedge clk);
`ifdef PWM_POLARITY_EN
    checks++;
    if (pwm_out !== 8'h01) begin
      errors++; $display("FAIL pol_idle got=%h exp=01", pwm_out);
    end
    rd(4'd6, d);
    checks++;
    if (d !== 32'd1) begin
      errors++; $display("FAIL pol_read got=%h exp=1", d);
    end
`else
    checks++;
    if (pwm_out !== 8'h00) begin
      errors++; $display("FAIL pol_absent_pwm got=%h exp=00", pwm_out);
    end
    rd(4'd6, d);
    checks++;
    if (d !== 32'd0) begin
      errors++; $display("FAIL pol_absent_read got=%h exp=0", d);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_presc();
    test_glitch_free();
    test_irq();
    test_reset_mid();
    test_polarity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
